prog_loader: RTL and testbench
==============================

# prog_loader

Serial program loader: the writer side of the instruction/data memory port that the multicycle CPU reads from. It accepts a framed byte stream and assembles big-endian 32-bit words. It writes them into `Memoria` through the same address/write-enable/data port the CPU uses, and holds the CPU in reset until a checksum-verified image is in place. It sits beside the CPU and muxes onto the memory port while `hold_cpu` is high.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000, byte address of the first word written; must be word-aligned.
- `MAX_WORDS`, 64, largest accepted image in words. The 256-byte `Memoria` gives 64.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  single-cycle pulse; begins or restarts a load.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `in_valid && in_ready`.
- `mem_addr`  out  32  byte address to memory.
- `mem_wr`  out  1  memory write enable, one cycle per word.
- `mem_wdata`  out  32  word to memory.
- `hold_cpu`  out  1  1 = CPU held in reset and memory port owned by the loader.
- `done`  out  1  image loaded and verified; level signal.
- `error`  out  1  frame rejected; level signal.

## Operation
- Frame format: 4-byte length `N` (words, MSB first), then `N`×4 data bytes (each word MSB first), then 1 checksum byte.
- Checksum: XOR of all `4N` data bytes. Length bytes are excluded.
- FSM states and transitions:
  - `IDLE`: `start` → `LEN`.
  - `LEN`: after the 4th length byte, `N==0` or `N>MAX_WORDS` → `ERR`; otherwise → `DATA`.
  - `DATA`: after the 4th byte of a word → `WRITE`.
  - `WRITE`: one cycle. If words written < `N` → `DATA`; else → `CHK`.
  - `CHK`: on the checksum byte, a match → `DONE`; a mismatch → `ERR`.
  - `DONE` / `ERR`: `start` → `LEN`.
- `start` in `LEN`, `DATA` or `CHK` aborts the frame and re-enters `LEN`. The byte counter, word counter and running checksum clear. Words already written stay in memory.
- `in_ready` = 1 only in `LEN`, `DATA` and `CHK`. It is 0 in `IDLE`, `WRITE`, `DONE` and `ERR`; bytes offered then are not consumed.
- Word `k` (0-based) is written at `BASE_ADDR + 4k`. The address is 32-bit modular; with `N ≤ MAX_WORDS` it never wraps in a legal configuration.
- `hold_cpu` = 1 in every state except `DONE`. A restart from `DONE` reasserts it on the cycle after `start`.
- `done` = 1 only in `DONE`. `error` = 1 only in `ERR`.
- Simultaneous `start` and a valid byte in `LEN`/`DATA`/`CHK`: `start` wins and the byte is dropped.

## Timing
- Reset values:
  - state = `IDLE`
  - `in_ready` = 0
  - `mem_wr` = 0
  - `mem_addr` = `BASE_ADDR`
  - `mem_wdata` = 0
  - `hold_cpu` = 1
  - `done` = 0
  - `error` = 0
  - all counters and the checksum = 0
- Reset asserted mid-frame returns the block to `IDLE` immediately (asynchronous). No `mem_wr` pulse may follow.
- `mem_addr`, `mem_wdata` and `mem_wr` are registered and valid together in the `WRITE` cycle. `mem_wr` is 0 in every other cycle.
- Latency: the 4th byte of a word is accepted in cycle t, and `mem_wr` = 1 in cycle t+1.
- Throughput: at most one byte per cycle. Each word costs 4 byte cycles plus 1 `WRITE` cycle.
- The checksum byte is accepted in cycle t, and `done` or `error` rises in cycle t+1.
- `Memoria` captures writes on `clk`. The loader never issues a read.

## Structure
- Shared include `loader_defs.vh` holds:
  - the state encoding (3-bit localparams `ST_IDLE`…`ST_ERR`);
  - the default `MAX_WORDS`.
- Sub-module `byte_assembler`:
  - 4-entry MSB-first shift register with a 2-bit byte counter;
  - outputs `word` and `word_ready`;
  - clear input driven by `start`;
  - reused for both the length field and the data words.
- The top module owns the FSM, word counter, address register and XOR accumulator.
- Estimated RTL: 180–260 lines total.

## Test plan
- **Reset:** hold `reset`=0 → all outputs at their reset values, `hold_cpu`=1. Release, no `start` → `in_ready` stays 0.
- **Normal load, `BASE_ADDR`=0:**
  - Stimulus: `start`, then bytes 00 00 00 02 | 24 08 00 05 | 01 09 50 20 | checksum 0x51.
  - Expected: `mem_wr` pulses at addresses 0x0 (0x24080005) and 0x4 (0x01095020), then `done`=1 and `hold_cpu`=0.
- **Bad checksum:** same frame with checksum 0x50 → both writes still occur, then `error`=1, `hold_cpu`=1, `done`=0.
- **Length rejection:**
  - Length 0x00000000 → `error`=1 after the 4th length byte, no `mem_wr`.
  - Length 0x00000041 with `MAX_WORDS`=64 → likewise.
- **Abort and backpressure:**
  - `start` mid-word (after 2 data bytes) → block returns to `LEN`; a following valid 1-word frame loads correctly at `BASE_ADDR`.
  - `in_valid` toggled randomly → identical memory contents.
- **Async reset mid-frame:** after 3 data bytes, pulse `reset`=0 → immediately `IDLE`, no `mem_wr`, `hold_cpu`=1. A new frame then loads normally.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// State encoding and sizing defaults shared by the program loader and its byte assembler.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  // 256-byte Memoria holds 64 words.
  localparam int unsigned MAX_WORDS_DEFAULT = 64;

endpackage

// File: rtl/byte_assembler.sv
// MSB-first byte-to-word assembler; word_ready flags the 4th byte combinationally so the
// consumer can act on the completed word in the same cycle the byte is accepted.
module byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  // The 4th byte is not stored; it is spliced in directly as the low byte.
  assign word       = {shift_q, byte_dat};
  assign word_ready = byte_vld && (cnt_q == 2'd3);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_vld) begin
      shift_d = {shift_q[15:0], byte_dat};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed serial program loader: length, big-endian data words, XOR checksum; writes words into
// Memoria and holds the CPU in reset until a verified image is in place.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        hold_cpu,
  output logic        done,
  output logic        error
);

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [7:0]  csum_q, csum_d;

  logic        byte_acc;
  logic        asm_vld;
  logic [31:0] asm_word;
  logic        asm_rdy;

  assign in_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
  // start wins over a coincident byte, which is dropped.
  assign byte_acc = in_valid && in_ready && !start;
  assign asm_vld  = byte_acc && (state_q != ST_CHK);

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = wr_q;
  assign hold_cpu  = (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERR);

  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (start),
    .byte_vld   (asm_vld),
    .byte_dat   (in_data),
    .word       (asm_word),
    .word_ready (asm_rdy)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    csum_d  = csum_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: ;
      ST_LEN: begin
        if (asm_rdy) begin
          len_d = asm_word;
          if ((asm_word == 32'd0) || (asm_word > MAX_WORDS)) state_d = ST_ERR;
          else                                               state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (byte_acc) begin
          csum_d = csum_q ^ in_data;
          if (asm_rdy) begin
            addr_d  = BASE_ADDR + {wcnt_q[29:0], 2'b00};
            wdata_d = asm_word;
            wr_d    = 1'b1;
            wcnt_d  = wcnt_q + 32'd1;
            state_d = ST_WRITE;
          end
        end
      end
      // wcnt_q already counts the word being written this cycle.
      ST_WRITE: state_d = (wcnt_q < len_q) ? ST_DATA : ST_CHK;
      ST_CHK: begin
        if (byte_acc) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase

    // WRITE is a single committed cycle; start elsewhere (re)opens a frame.
    if (start && (state_q != ST_WRITE)) begin
      state_d = ST_LEN;
      len_d   = '0;
      wcnt_d  = '0;
      csum_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      csum_q  <= csum_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued by the stimulus and
// popped by an independent monitor whenever mem_wr is seen.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        hold_cpu;
  logic        done;
  logic        error;

  int          checks = 0;
  int          errors = 0;
  bit          bp_en = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  always #5 clk = ~clk;

  prog_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .hold_cpu  (hold_cpu),
    .done      (done),
    .error     (error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (bp_en) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 3; i >= 0; i--) send_byte(n[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("wr_latency", 32'(mem_wr), 32'd1);
  endtask

  task automatic pulse_start(input bit with_byte);
    @(negedge clk);
    start    = 1'b1;
    in_valid = with_byte;
    in_data  = 8'h5A;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic end_frame(input logic [7:0] cs, input bit good);
    send_byte(cs);
    @(negedge clk);
    in_valid = 1'b0;
    chk("done", 32'(done), 32'(good));
    chk("error", 32'(error), 32'(!good));
    chk("hold_cpu", 32'(hold_cpu), 32'(!good));
    chk("in_ready_end", 32'(in_ready), 32'd0);
  endtask

  task automatic expect_len_reject(input logic [31:0] n);
    pulse_start(1'b0);
    send_len(n);
    @(negedge clk);
    in_valid = 1'b0;
    chk("len_err", 32'(error), 32'd1);
    chk("len_err_ready", 32'(in_ready), 32'd0);
    chk("len_err_hold", 32'(hold_cpu), 32'd1);
  endtask

  // Monitor: every write must match the oldest expected one; a write with nothing queued is a fault.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", mem_addr, mon_e[63:32]);
          chk("wr_data", mem_wdata, mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0000_0000);
    chk("rst_mem_wdata", mem_wdata, 32'h0000_0000);
    chk("rst_hold_cpu", 32'(hold_cpu), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_hold_cpu", 32'(hold_cpu), 32'd1);

    // Normal two-word load
    pulse_start(1'b0);
    chk("len_in_ready", 32'(in_ready), 32'd1);
    expect_wr(32'h0, 32'h2408_0005);
    expect_wr(32'h4, 32'h0109_5020);
    send_len(32'd2);
    send_word(32'h2408_0005);
    send_word(32'h0109_5020);
    end_frame(8'h51, 1'b1);

    // Restart from DONE, bad checksum
    pulse_start(1'b0);
    chk("restart_hold", 32'(hold_cpu), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    expect_wr(32'h0, 32'h2408_0005);
    expect_wr(32'h4, 32'h0109_5020);
    send_len(32'd2);
    send_word(32'h2408_0005);
    send_word(32'h0109_5020);
    end_frame(8'h50, 1'b0);

    // Length rejection
    expect_len_reject(32'h0000_0000);
    expect_len_reject(32'h0000_0041);

    // Abort mid-word; the byte coincident with start must be dropped
    pulse_start(1'b0);
    send_len(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_start(1'b1);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_error", 32'(error), 32'd0);
    expect_wr(32'h0, 32'hDEAD_BEEF);
    send_len(32'd1);
    send_word(32'hDEAD_BEEF);
    end_frame(8'h22, 1'b1);

    // Random gaps on the byte stream
    bp_en = 1'b1;
    pulse_start(1'b0);
    expect_wr(32'h0, 32'h1122_3344);
    expect_wr(32'h4, 32'hA5A5_A5A5);
    expect_wr(32'h8, 32'h00FF_00FF);
    send_len(32'd3);
    send_word(32'h1122_3344);
    send_word(32'hA5A5_A5A5);
    send_word(32'h00FF_00FF);
    end_frame(8'h44, 1'b1);
    bp_en = 1'b0;

    // Asynchronous reset mid-frame
    pulse_start(1'b0);
    send_len(32'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_hold_cpu", 32'(hold_cpu), 32'd1);
    chk("arst_mem_wr", 32'(mem_wr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_idle_ready", 32'(in_ready), 32'd0);
    pulse_start(1'b0);
    expect_wr(32'h0, 32'hCAFE_F00D);
    send_len(32'd1);
    send_word(32'hCAFE_F00D);
    end_frame(8'hC9, 1'b1);

    repeat (3) @(negedge clk);
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
